// File: rtl/hpi_xfer_ctrl.sv
// hpi_xfer_ctrl
// Drives a host-port-interface (HPI) chip with a chip-reset hold sequence
// followed by single-word or burst register transfers.
// Each word runs SETUP_CYC setup cycles, STROBE_CYC strobe cycles and
// HOLD_CYC hold cycles.
//
// Optional feature: define HPI_BURST_EN to enable multi-word bursts.
// When it is undefined, every request is exactly one word, req_len is
// ignored and wr_ready stays low.
//
// Ports
//   clk_clk, reset_reset              clock, synchronous active-high reset
//   req_valid/req_ready               request handshake
//   req_write, req_port, req_len      request fields (len 0 means 1 word)
//   wr_data / wr_ready                write word in, consume pulse per next word
//   rd_data / rd_valid                captured read word, one-cycle valid pulse
//   busy, done                        activity flag, one-cycle completion pulse
//   hpi_addr, hpi_data_out,
//   hpi_data_in, hpi_r_n, hpi_w_n,
//   hpi_cs_n, hpi_rst_n               chip pins (strobes active low)
module hpi_xfer_ctrl #(
    parameter int DATA_W     = 16,
    parameter int LEN_W      = 5,
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 2,
    parameter int RST_CYC    = 16
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_port,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic [1:0]        hpi_addr,
    output logic [DATA_W-1:0] hpi_data_out,
    input  logic [DATA_W-1:0] hpi_data_in,
    output logic              hpi_r_n,
    output logic              hpi_w_n,
    output logic              hpi_cs_n,
    output logic              hpi_rst_n
);

    localparam int PH_MAX = (SETUP_CYC > STROBE_CYC) ?
                            ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                            ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int RST_W  = $clog2(RST_CYC + 1);

    typedef enum logic [2:0] {
        RST_HOLD,
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } state_t;

    state_t             state, state_nx;
    logic [PH_W-1:0]    ph_cnt;
    logic [RST_W-1:0]   rst_cnt;
    logic               write_q;
    logic               phase_last;
    logic               rst_last;
    logic               accept;
    logic               last_word;

    assign accept   = (state == IDLE) && req_valid;
    assign rst_last = (rst_cnt == RST_W'(RST_CYC - 1));

    always_comb begin
        phase_last = 1'b0;
        case (state)
            SETUP:   phase_last = (ph_cnt == PH_W'(SETUP_CYC - 1));
            STROBE:  phase_last = (ph_cnt == PH_W'(STROBE_CYC - 1));
            HOLD:    phase_last = (ph_cnt == PH_W'(HOLD_CYC - 1));
            default: phase_last = 1'b0;
        endcase
    end

`ifdef HPI_BURST_EN
    logic [LEN_W-1:0] rem_q;

    // Remaining words including the one in flight; saturates at zero.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            rem_q <= '0;
        end else if (accept) begin
            rem_q <= (req_len == '0) ? LEN_W'(1) : req_len;
        end else if (state == HOLD && phase_last && rem_q != '0) begin
            rem_q <= rem_q - 1'b1;
        end
    end

    assign last_word = (rem_q == LEN_W'(1));
`else
    logic unused_len;
    assign unused_len = ^req_len;
    assign last_word  = 1'b1;
`endif

    // State register
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state <= RST_HOLD;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            RST_HOLD: if (rst_last)   state_nx = IDLE;
            IDLE:     if (req_valid)  state_nx = SETUP;
            SETUP:    if (phase_last) state_nx = STROBE;
            STROBE:   if (phase_last) state_nx = HOLD;
            HOLD:     if (phase_last) state_nx = last_word ? IDLE : SETUP;
            default:  state_nx = RST_HOLD;
        endcase
    end

    // Output decode
    always_comb begin
        req_ready = (state == IDLE);
        busy      = (state != IDLE);
        hpi_rst_n = (state != RST_HOLD);
        hpi_cs_n  = !(state == SETUP || state == STROBE || state == HOLD);
        hpi_w_n   = !(state == STROBE && write_q);
        hpi_r_n   = !(state == STROBE && !write_q);
`ifdef HPI_BURST_EN
        wr_ready  = (state == HOLD) && phase_last && write_q && !last_word;
`else
        wr_ready  = 1'b0;
`endif
    end

    // Counters, latched request fields and registered pulses
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            rst_cnt      <= '0;
            ph_cnt       <= '0;
            write_q      <= 1'b0;
            hpi_addr     <= '0;
            hpi_data_out <= '0;
            rd_data      <= '0;
            rd_valid     <= 1'b0;
            done         <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;

            if (state == RST_HOLD && !rst_last) begin
                rst_cnt <= rst_cnt + 1'b1;
            end

            if (state == SETUP || state == STROBE || state == HOLD) begin
                ph_cnt <= phase_last ? '0 : ph_cnt + 1'b1;
            end else begin
                ph_cnt <= '0;
            end

            if (accept) begin
                write_q      <= req_write;
                hpi_addr     <= req_port;
                hpi_data_out <= req_write ? wr_data : '0;
            end

            // Read data is taken only on the edge that ends the strobe.
            if (state == STROBE && phase_last && !write_q) begin
                rd_data  <= hpi_data_in;
                rd_valid <= 1'b1;
            end

            // The next burst word is taken on the same edge wr_ready is high.
            if (state == HOLD && phase_last) begin
                if (last_word) begin
                    done <= 1'b1;
                end else if (write_q) begin
                    hpi_data_out <= wr_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_hpi_xfer_ctrl.sv
// tb_hpi_xfer_ctrl
// Self-checking bench for hpi_xfer_ctrl: reset sequence, single and burst
// transfers with randomized data, length boundaries, mid-transfer reset.
// Works with or without HPI_BURST_EN defined.
module tb_hpi_xfer_ctrl;

    localparam int DATA_W = 16;
    localparam int LEN_W  = 5;

    logic              clk_clk = 1'b0;
    logic              reset_reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_port;
    logic [LEN_W-1:0]  req_len;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              busy;
    logic              done;
    logic [1:0]        hpi_addr;
    logic [DATA_W-1:0] hpi_data_out;
    logic [DATA_W-1:0] hpi_data_in;
    logic              hpi_r_n;
    logic              hpi_w_n;
    logic              hpi_cs_n;
    logic              hpi_rst_n;

    int errors = 0;
    int checks = 0;
    bit inv_en = 1'b0;

    hpi_xfer_ctrl #(
        .DATA_W     (DATA_W),
        .LEN_W      (LEN_W),
        .SETUP_CYC  (2),
        .STROBE_CYC (4),
        .HOLD_CYC   (2),
        .RST_CYC    (16)
    ) dut (
        .clk_clk      (clk_clk),
        .reset_reset  (reset_reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_port     (req_port),
        .req_len      (req_len),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .busy         (busy),
        .done         (done),
        .hpi_addr     (hpi_addr),
        .hpi_data_out (hpi_data_out),
        .hpi_data_in  (hpi_data_in),
        .hpi_r_n      (hpi_r_n),
        .hpi_w_n      (hpi_w_n),
        .hpi_cs_n     (hpi_cs_n),
        .hpi_rst_n    (hpi_rst_n)
    );

    always #5 clk_clk = ~clk_clk;

    // Pin-level safety: strobes never overlap and never assert without chip select.
    always @(negedge clk_clk) begin
        if (inv_en) begin
            checks++;
            if (((!hpi_w_n && !hpi_r_n) || (hpi_cs_n && (!hpi_w_n || !hpi_r_n))) !== 1'b0) begin
                errors++;
                $display("FAIL strobe_safety t=%0t: cs_n=%b w_n=%b r_n=%b, required no overlap and no strobe without cs",
                         $time, hpi_cs_n, hpi_w_n, hpi_r_n);
            end
        end
    end

    initial begin
        #600000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    function automatic int exp_words(input int len);
`ifdef HPI_BURST_EN
        return (len == 0) ? 1 : len;
`else
        return 1;
`endif
    endfunction

    task automatic test_reset;
        reset_reset = 1'b1;
        repeat (3) @(posedge clk_clk);
        #1;
        inv_en = 1'b1;
        checks++;
        if ({hpi_cs_n, hpi_r_n, hpi_w_n, hpi_rst_n, rd_valid, wr_ready, done, req_ready, busy} !== 9'b111_0_000_0_1) begin
            errors++;
            $display("FAIL reset_ctrl: cs,r,w,rst,rdv,wrr,done,rdy,busy=%b required 111000001",
                     {hpi_cs_n, hpi_r_n, hpi_w_n, hpi_rst_n, rd_valid, wr_ready, done, req_ready, busy});
        end
        checks++;
        if (hpi_addr !== 2'd0 || hpi_data_out !== '0 || rd_data !== '0) begin
            errors++;
            $display("FAIL reset_data: addr=%0d data_out=%h rd_data=%h required 0 0 0",
                     hpi_addr, hpi_data_out, rd_data);
        end
        reset_reset = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk_clk);
            #1;
            checks++;
            if (k < 16) begin
                if (hpi_rst_n !== 1'b0 || req_ready !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL rst_hold cyc%0d: rst_n=%b ready=%b busy=%b required 0 0 1",
                             k, hpi_rst_n, req_ready, busy);
                end
            end else begin
                if (hpi_rst_n !== 1'b1 || req_ready !== 1'b1 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_release: rst_n=%b ready=%b busy=%b required 1 1 0",
                             hpi_rst_n, req_ready, busy);
                end
            end
        end
    endtask

    // Issues one request and checks every pin cycle by cycle against the
    // per-word timeline (2 setup, 4 strobe, 2 hold), then the done cycle.
    task automatic run_xfer(input bit wr, input logic [1:0] port, input int len,
                            input bit step_rd, input logic [15:0] first_wd, input string name);
        int nw, total, w, p, n_wr, n_rd, n_done;
        bit strobe, active;
        logic [15:0] wd[32];
        logic [15:0] rd[32];
        nw = exp_words(len);
        total = nw * 8 + 1;
        n_wr = 0; n_rd = 0; n_done = 0;
        for (int i = 0; i < 32; i++) begin
            wd[i] = 16'($urandom);
            rd[i] = step_rd ? 16'(16'hA000 + i) : 16'($urandom);
        end
        wd[0] = first_wd;
        req_valid = 1'b1;
        req_write = wr;
        req_port = port;
        req_len = LEN_W'(len);
        wr_data = wd[0];
        hpi_data_in = 16'($urandom);
        @(posedge clk_clk);
        #1;
        for (int c = 1; c <= total; c++) begin
            active = (c <= nw * 8);
            w = (c - 1) / 8;
            p = (c - 1) % 8;
            strobe = (p >= 2 && p <= 5);
            if (active) begin
                checks++;
                if (hpi_cs_n !== 1'b0 || hpi_addr !== port || busy !== 1'b1 || req_ready !== 1'b0 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL %s ctrl cyc%0d: cs_n=%b addr=%0d busy=%b ready=%b done=%b required 0 %0d 1 0 0",
                             name, c, hpi_cs_n, hpi_addr, busy, req_ready, done, port);
                end
                checks++;
                if (hpi_w_n !== !(wr && strobe) || hpi_r_n !== !(!wr && strobe)) begin
                    errors++;
                    $display("FAIL %s strobes cyc%0d: w_n=%b r_n=%b required %b %b",
                             name, c, hpi_w_n, hpi_r_n, !(wr && strobe), !(!wr && strobe));
                end
                if (wr) begin
                    checks++;
                    if (hpi_data_out !== wd[w]) begin
                        errors++;
                        $display("FAIL %s data_out cyc%0d: got %h required %h", name, c, hpi_data_out, wd[w]);
                    end
                end
                checks++;
                if (wr_ready !== (wr && p == 7 && w < nw - 1)) begin
                    errors++;
                    $display("FAIL %s wr_ready cyc%0d: got %b required %b", name, c, wr_ready, (wr && p == 7 && w < nw - 1));
                end
                checks++;
                if (rd_valid !== (!wr && p == 6)) begin
                    errors++;
                    $display("FAIL %s rd_valid cyc%0d: got %b required %b", name, c, rd_valid, (!wr && p == 6));
                end
                if (!wr && p == 6) begin
                    checks++;
                    if (rd_data !== rd[w]) begin
                        errors++;
                        $display("FAIL %s rd_data word%0d: got %h required %h", name, w, rd_data, rd[w]);
                    end
                end
            end else begin
                checks++;
                if ({hpi_cs_n, hpi_w_n, hpi_r_n, done, busy, req_ready} !== 6'b111101) begin
                    errors++;
                    $display("FAIL %s done_cycle: cs,w,r,done,busy,rdy=%b required 111101",
                             name, {hpi_cs_n, hpi_w_n, hpi_r_n, done, busy, req_ready});
                end
            end
            if (wr_ready === 1'b1) n_wr++;
            if (rd_valid === 1'b1) n_rd++;
            if (done === 1'b1) n_done++;
            // Junk request held during the transfer must be ignored.
            if (c < total) begin
                req_valid = 1'b1;
                req_write = 1'($urandom);
                req_port  = 2'($urandom);
                req_len   = LEN_W'($urandom);
            end else begin
                req_valid = 1'b0;
            end
            wr_data = (active && p == 7 && w + 1 < nw) ? wd[w + 1] : 16'($urandom);
            hpi_data_in = (active && !wr && p == 5) ? rd[w] : 16'($urandom);
            @(posedge clk_clk);
            #1;
        end
        checks++;
        if (n_wr != (wr ? nw - 1 : 0) || n_rd != (wr ? 0 : nw) || n_done != 1) begin
            errors++;
            $display("FAIL %s pulse_counts: wr_ready=%0d rd_valid=%0d done=%0d required %0d %0d 1",
                     name, n_wr, n_rd, n_done, wr ? nw - 1 : 0, wr ? 0 : nw);
        end
    endtask

    task automatic test_single_write;
        run_xfer(1'b1, 2'd2, 1, 1'b0, 16'h1234, "single_write");
    endtask

    task automatic test_read_burst;
        run_xfer(1'b0, 2'd0, 3, 1'b1, 16'h0000, "read_burst3");
        run_xfer(1'b0, 2'd3, 5, 1'b0, 16'h0000, "read_len5");
    endtask

    task automatic test_write_burst;
        run_xfer(1'b1, 2'd1, 4, 1'b0, 16'($urandom), "write_burst4");
    endtask

    task automatic test_len_bounds;
        run_xfer(1'b1, 2'd3, 0, 1'b0, 16'($urandom), "len0_write");
        run_xfer(1'b0, 2'd2, 31, 1'b0, 16'h0000, "len31_read");
    endtask

    task automatic test_random;
        for (int i = 0; i < 10; i++) begin
            run_xfer(1'($urandom), 2'($urandom), int'($urandom_range(0, 6)), 1'b0,
                     16'($urandom), "random");
        end
    endtask

    task automatic test_reset_mid_read;
        int tc;
        tc = (exp_words(3) > 1) ? 12 : 4;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_port = 2'd1;
        req_len = LEN_W'(3);
        hpi_data_in = 16'($urandom);
        @(posedge clk_clk);
        #1;
        req_valid = 1'b0;
        repeat (tc - 1) begin
            hpi_data_in = 16'($urandom);
            @(posedge clk_clk);
            #1;
        end
        checks++;
        if (hpi_r_n !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_strobe: r_n=%b required 0", hpi_r_n);
        end
        reset_reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_clk);
            #1;
            checks++;
            if ({hpi_cs_n, hpi_r_n, hpi_w_n, hpi_rst_n, rd_valid, wr_ready, done, req_ready, busy} !== 9'b111_0_000_0_1
                || hpi_addr !== 2'd0 || hpi_data_out !== '0 || rd_data !== '0) begin
                errors++;
                $display("FAIL mid_reset_hold%0d: cs,r,w,rst,rdv,wrr,done,rdy,busy=%b addr=%0d dout=%h rd=%h required 111000001 0 0 0",
                         k, {hpi_cs_n, hpi_r_n, hpi_w_n, hpi_rst_n, rd_valid, wr_ready, done, req_ready, busy},
                         hpi_addr, hpi_data_out, rd_data);
            end
        end
        reset_reset = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk_clk);
            #1;
            checks++;
            if (k < 16) begin
                if (hpi_rst_n !== 1'b0 || done !== 1'b0 || req_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL mid_reset_rsthold cyc%0d: rst_n=%b done=%b ready=%b required 0 0 0",
                             k, hpi_rst_n, done, req_ready);
                end
            end else if (hpi_rst_n !== 1'b1 || req_ready !== 1'b1) begin
                errors++;
                $display("FAIL mid_reset_release: rst_n=%b ready=%b required 1 1", hpi_rst_n, req_ready);
            end
        end
        run_xfer(1'b1, 2'd0, 2, 1'b0, 16'($urandom), "after_reset");
    endtask

    initial begin
        reset_reset = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_port = 2'd0;
        req_len = '0;
        wr_data = '0;
        hpi_data_in = '0;
        test_reset;
        test_single_write;
        test_read_burst;
        test_write_burst;
        test_len_bounds;
        test_random;
        test_reset_mid_read;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hpi_xfer_ctrl.md
HPI_XFER_CTRL -- requirements
Module: hpi_xfer_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16: HPI data bus width.
REQ-002 SHALL have parameter LEN_W, default 5: burst-length field width; maximum burst is 2^LEN_W-1 words.
REQ-003 SHALL have parameters SETUP_CYC, STROBE_CYC and HOLD_CYC, defaults 2/4/2: per-phase cycle counts, each >=1.
REQ-004 SHALL have parameter RST_CYC, default 16: chip-reset low time in cycles.
REQ-005 clk_clk  in  1  sole clock; all logic rising-edge.
REQ-006 reset_reset  in  1  synchronous, active-high reset.
REQ-007 req_valid  in  1 / req_ready  out  1  request handshake; a request transfers when both are high on a clock edge.
REQ-008 req_write  in  1 / req_port  in  2 / req_len  in  LEN_W  request fields: write flag, HPI register (0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS), word count.
REQ-009 wr_data  in  DATA_W / wr_ready  out  1  write-data input and one-cycle consume pulse.
REQ-010 rd_data  out  DATA_W / rd_valid  out  1  read word and one-cycle valid pulse.
REQ-011 busy  out  1 / done  out  1  transfer or reset in progress; one-cycle completion pulse.
REQ-012 hpi_addr  out  2 / hpi_data_out  out  DATA_W / hpi_data_in  in  DATA_W / hpi_r_n, hpi_w_n, hpi_cs_n, hpi_rst_n  out  1 each  chip pins, active-low strobes.

Function
REQ-013 SHALL implement the states RST_HOLD, IDLE, SETUP, STROBE and HOLD.
REQ-014 RST_HOLD: hpi_rst_n=0 for RST_CYC cycles, then IDLE; busy=1 and req_ready=0 throughout.
REQ-015 IDLE: req_ready=1 and busy=0; on handshake SHALL latch write, port, len (req_len=0 treated as 1) and wr_data, then go to SETUP.
REQ-016 SETUP: hpi_cs_n=0, hpi_addr=port, hpi_data_out=current word (write only), both strobes high; SHALL last SETUP_CYC cycles, then go to STROBE.
REQ-017 STROBE: hpi_w_n=0 for a write, or hpi_r_n=0 for a read, for STROBE_CYC cycles.
REQ-018 Read capture: on the last STROBE cycle SHALL register hpi_data_in into rd_data and pulse rd_valid in the following cycle.
REQ-019 HOLD: both strobes high, hpi_cs_n=0, hpi_addr and hpi_data_out unchanged; SHALL last HOLD_CYC cycles.
REQ-020 After the last HOLD cycle with words remaining: go to SETUP.
REQ-021 After the last HOLD cycle with no words remaining: hpi_cs_n=1, done=1 for exactly one cycle, return to IDLE.
REQ-022 Write bursts: wr_ready SHALL pulse in the last HOLD cycle of every word except the final word; wr_data sampled on that edge becomes the next word, and the caller cannot stall.
REQ-023 Per-word latency SHALL be exactly SETUP_CYC+STROBE_CYC+HOLD_CYC cycles; request acceptance to done = len*(that sum)+1 cycles.
REQ-024 hpi_w_n and hpi_r_n SHALL never be low simultaneously.
REQ-025 Neither strobe SHALL go low while hpi_cs_n=1.
REQ-026 The remaining-word counter SHALL decrement once per word and never wrap.
REQ-027 req_valid asserted while not IDLE SHALL be ignored; the request is held by the caller.
REQ-028 hpi_data_in SHALL be ignored outside the read capture cycle.

Reset
REQ-029 reset_reset high SHALL, at the next edge from any state: set hpi_cs_n, hpi_r_n and hpi_w_n to 1, hpi_rst_n to 0, hpi_addr, hpi_data_out and rd_data to 0, rd_valid, wr_ready, done and req_ready to 0, busy to 1; SHALL abort any transfer without a done pulse; SHALL enter RST_HOLD with the reset counter cleared.
REQ-030 While reset_reset stays high, outputs SHALL hold these values; RST_HOLD counting SHALL begin on the first cycle after release.

Configuration
REQ-031 Macro HPI_BURST_EN defined: bursts SHALL behave per REQ-015 to REQ-022.
REQ-032 HPI_BURST_EN undefined: req_len SHALL be ignored, every request SHALL be treated as exactly one word, and wr_ready SHALL stay 0; the counter logic SHALL be removed.

Verification
REQ-033 Release reset -> hpi_rst_n low 16 cycles then high; req_ready rises the cycle after.
REQ-034 Write, port 2, len 1, wr_data 0x1234 -> cs_n low 8 cycles, w_n low cycles 3-6, data_out 0x1234, done at acceptance+9.
REQ-035 Read, port 0, len 3, hpi_data_in stepping 0xA000/0xA001/0xA002 per word -> three rd_valid pulses 8 cycles apart with those values, cs_n continuously low, one done pulse.
REQ-036 Write burst len 4, HPI_BURST_EN defined -> exactly 3 wr_ready pulses; all 4 words appear on hpi_data_out in order.
REQ-037 reset_reset asserted during the STROBE of word 2 of a read burst -> next edge: strobes and cs_n high, no done pulse, RST_HOLD re-entered.
REQ-038 HPI_BURST_EN undefined, read len 5 -> exactly 1 rd_valid pulse, done at acceptance+9.
